// File: rtl/channel_stream_reader.sv
// -----------------------------------------------------------------------------
// channel_stream_reader
//
// Streams N_CHANNELS planar image channels from a single synchronous RAM into
// the per-channel data/valid inputs of spatial_conv_core. One read is launched
// per cycle, round-robin over the channels that still have pixels left and that
// have credit. A channel has credit while (reads in flight + words buffered) < 2.
// Each channel owns a 2-entry skid FIFO. The credit rule guarantees that every
// returning RAM word finds room in its FIFO, so no word is dropped or repeated.
//
// Optional feature (macro CHANNEL_READER_STALL_CNT_EN):
//   Adds stall_cnt_o, a saturating 32-bit count of RUN cycles in which no read
//   was launched. It clears on reset and when a frame starts, and holds its
//   value while IDLE or DONE.
//
// Ports
//   clock_i       in   1                      clock, all logic on posedge
//   reset_i       in   1                      synchronous reset, active-high
//   start_i       in   1                      starts one frame when IDLE
//   hold_i        in   N_CHANNELS             consumer back-pressure per channel
//   ram_addr_o    out  ADDR_WIDTH             RAM read address
//   ram_rden_o    out  1                      read issued this cycle
//   ram_q_i       in   DATA_WIDTH             RAM data, RAM_LATENCY after rden
//   data_o        out  N_CHANNELS*DATA_WIDTH  head word of each channel FIFO
//   data_valid_o  out  N_CHANNELS             channel FIFO not empty
//   busy_o        out  1                      frame in progress (RUN/DRAIN)
//   done_o        out  1                      one-cycle pulse at end of frame
//   stall_cnt_o   out  32                     only with CHANNEL_READER_STALL_CNT_EN
// -----------------------------------------------------------------------------
module channel_stream_reader #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int N_ROWS      = 100,
    parameter int N_COLS      = 100,
    parameter int N_CHANNELS  = 3,
    parameter int BASE_ADDR   = 0,
    parameter int RAM_LATENCY = 1
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic [N_CHANNELS-1:0]            hold_i,
    output logic [ADDR_WIDTH-1:0]            ram_addr_o,
    output logic                             ram_rden_o,
    input  logic [DATA_WIDTH-1:0]            ram_q_i,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic [N_CHANNELS-1:0]            data_valid_o,
    output logic                             busy_o,
    output logic                             done_o
`ifdef CHANNEL_READER_STALL_CNT_EN
    ,
    output logic [31:0]                      stall_cnt_o
`endif
);

    localparam int FRAME = N_ROWS * N_COLS;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam logic [CH_W:0]   NCH_WIDE = (CH_W+1)'(N_CHANNELS);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_rr;
    logic                  r_rden;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CH_W-1:0]       r_rd_ch;
    logic                  r_busy;
    logic                  r_done;
    // Tag pipe: stage k carries the read launched k+1 cycles ago, so the last
    // stage lines up with the word currently on ram_q_i.
    logic                  r_tag_vld [RAM_LATENCY];
    logic [CH_W-1:0]       r_tag_ch  [RAM_LATENCY];

    logic [N_CHANNELS-1:0] w_elig;
    logic [N_CHANNELS-1:0] w_iss;
    logic [N_CHANNELS-1:0] w_push;
    logic [N_CHANNELS-1:0] w_last;
    logic [N_CHANNELS-1:0] w_empty;
    logic [ADDR_WIDTH-1:0] w_ch_addr [N_CHANNELS];
    logic [CH_W-1:0]       w_sel;
    logic [CH_W-1:0]       w_rr_next;
    logic [CH_W:0]         w_idx;
    logic                  w_found;
    logic                  w_issue;

    // Round-robin pick: first eligible channel at or after the rr pointer.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            w_idx = {1'b0, r_rr} + (CH_W+1)'(k);
            if (w_idx >= NCH_WIDE) begin
                w_idx = w_idx - NCH_WIDE;
            end
            if (!w_found && w_elig[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[CH_W-1:0];
            end
        end
    end

    assign w_issue   = (r_state == S_RUN) && w_found;
    assign w_rr_next = (w_sel == CH_LAST) ? '0 : w_sel + CH_W'(1);

    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
            localparam logic [ADDR_WIDTH-1:0] PLANE_BASE = ADDR_WIDTH'(BASE_ADDR + gi * FRAME);

            logic [CNT_W-1:0]      r_cnt;
            logic [1:0]            r_inf;
            logic [1:0]            r_occ;
            logic [DATA_WIDTH-1:0] r_mem [2];
            logic                  r_wr_ptr;
            logic                  r_rd_ptr;
            logic [2:0]            w_credit;
            logic                  w_pop;

            assign w_credit        = {1'b0, r_inf} + {1'b0, r_occ};
            assign w_elig[gi]      = (r_cnt < CNT_W'(FRAME)) && (w_credit < 3'd2);
            assign w_iss[gi]       = w_issue && (w_sel == CH_W'(gi));
            assign w_push[gi]      = r_tag_vld[RAM_LATENCY-1] && (r_tag_ch[RAM_LATENCY-1] == CH_W'(gi));
            assign w_pop           = (r_occ != 2'd0) && !hold_i[gi];
            // Counts the read launched this cycle, so RUN ends on the cycle of
            // the final read rather than idling one extra cycle.
            assign w_last[gi]      = (r_cnt == CNT_W'(FRAME)) ||
                                     (w_iss[gi] && (r_cnt == CNT_W'(FRAME - 1)));
            assign w_empty[gi]     = (r_inf == 2'd0) && (r_occ == 2'd0);
            assign w_ch_addr[gi]   = PLANE_BASE + ADDR_WIDTH'(r_cnt);
            assign data_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr];
            assign data_valid_o[gi] = (r_occ != 2'd0);

            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    r_cnt    <= '0;
                    r_inf    <= '0;
                    r_occ    <= '0;
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_wr_ptr <= 1'b0;
                    r_rd_ptr <= 1'b0;
                end else begin
                    if ((r_state == S_IDLE) && start_i) begin
                        r_cnt <= '0;
                    end else if (w_iss[gi]) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    r_inf <= r_inf + {1'b0, w_iss[gi]} - {1'b0, w_push[gi]};
                    r_occ <= r_occ + {1'b0, w_push[gi]} - {1'b0, w_pop};
                    if (w_push[gi]) begin
                        r_mem[r_wr_ptr] <= ram_q_i;
                        r_wr_ptr        <= ~r_wr_ptr;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_rden  <= 1'b0;
            r_addr  <= '0;
            r_rd_ch <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_ch[i]  <= '0;
            end
        end else begin
            r_rden  <= w_issue;
            r_rd_ch <= w_sel;
            if (w_issue) begin
                r_addr <= w_ch_addr[w_sel];
                r_rr   <= w_rr_next;
            end
            r_tag_vld[0] <= r_rden;
            r_tag_ch[0]  <= r_rd_ch;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_ch[i]  <= r_tag_ch[i-1];
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_rr    <= '0;
                    end
                end
                S_RUN: begin
                    if (&w_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Empty FIFOs and zero in-flight reads mean every word
                    // has been handed to the consumer.
                    if (&w_empty) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ram_rden_o = r_rden;
    assign ram_addr_o = r_addr;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

`ifdef CHANNEL_READER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Counts RUN cycles in which no read was launched; saturates.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !w_issue && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_channel_stream_reader.sv
module tb_channel_stream_reader;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with RAM_LATENCY = 1
    logic           rst, start;
    logic [NC-1:0]  hold;
    logic [AW-1:0]  addr;
    logic           rden;
    logic [DW-1:0]  q;
    logic [NC*DW-1:0] dout;
    logic [NC-1:0]  dv;
    logic           busy, done;
`ifdef CHANNEL_READER_STALL_CNT_EN
    logic [31:0]    stall;
    logic [31:0]    stall3;
`endif

    // DUT with RAM_LATENCY = 3
    logic           rst3, start3;
    logic [NC-1:0]  hold3;
    logic [AW-1:0]  addr3;
    logic           rden3;
    logic [DW-1:0]  q3;
    logic [NC*DW-1:0] dout3;
    logic [NC-1:0]  dv3;
    logic           busy3, done3;

    channel_stream_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_ROWS(2), .N_COLS(2),
        .N_CHANNELS(NC), .BASE_ADDR(0), .RAM_LATENCY(1)
    ) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .hold_i(hold),
        .ram_addr_o(addr), .ram_rden_o(rden), .ram_q_i(q),
        .data_o(dout), .data_valid_o(dv), .busy_o(busy), .done_o(done)
`ifdef CHANNEL_READER_STALL_CNT_EN
        , .stall_cnt_o(stall)
`endif
    );

    channel_stream_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_ROWS(2), .N_COLS(2),
        .N_CHANNELS(NC), .BASE_ADDR(0), .RAM_LATENCY(3)
    ) dut3 (
        .clock_i(clk), .reset_i(rst3), .start_i(start3), .hold_i(hold3),
        .ram_addr_o(addr3), .ram_rden_o(rden3), .ram_q_i(q3),
        .data_o(dout3), .data_valid_o(dv3), .busy_o(busy3), .done_o(done3)
`ifdef CHANNEL_READER_STALL_CNT_EN
        , .stall_cnt_o(stall3)
`endif
    );

    // RAM models: mem[a] = a
    always @(posedge clk) q <= 32'(addr);
    logic [DW-1:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= 32'(addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q3 = p3[2];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done3_cnt = 0;
    logic prev_busy = 1'b0;

    int exp_a[$];
    int exp_d[NC][$];
    int exp3[NC][$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read or a word
    initial begin
        forever begin
            @(negedge clk);
            if (rden) begin
                if (exp_a.size() == 0) chk("addr_unexpected", longint'(addr), -1);
                else chk("addr", longint'(addr), exp_a.pop_front());
            end
            for (int c = 0; c < NC; c++) begin
                if (dv[c] && !hold[c]) begin
                    if (exp_d[c].size() == 0)
                        chk($sformatf("data_ch%0d_unexpected", c), longint'(dout[c*DW +: DW]), -1);
                    else
                        chk($sformatf("data_ch%0d", c), longint'(dout[c*DW +: DW]), exp_d[c].pop_front());
                end
                if (dv3[c] && !hold3[c]) begin
                    if (exp3[c].size() == 0)
                        chk($sformatf("lat3_ch%0d_unexpected", c), longint'(dout3[c*DW +: DW]), -1);
                    else
                        chk($sformatf("lat3_ch%0d", c), longint'(dout3[c*DW +: DW]), exp3[c].pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", longint'(busy), 0);
                chk("busy_before_done", longint'(prev_busy), 1);
            end
            if (done3) done3_cnt++;
            prev_busy = busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int seq[12]);
        for (int i = 0; i < 12; i++) exp_a.push_back(seq[i]);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < 4; k++) exp_d[c].push_back(4*c + k);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, longint'(n < 300), 1);
        repeat (2) step();
    endtask

    task automatic leftovers(input string name);
        chk({name, "_addr_left"}, exp_a.size(), 0);
        chk({name, "_data_left"}, exp_d[0].size() + exp_d[1].size() + exp_d[2].size(), 0);
    endtask

    int seq_plain[12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    int seq_hold1[12] = '{0, 4, 8, 1, 5, 9, 2, 10, 3, 11, 6, 7};

    initial begin
        int d0, run, n, cnt, bad;
        rst = 1'b1; start = 1'b0; hold = '0;
        rst3 = 1'b1; start3 = 1'b0; hold3 = '0;
        step();
        rst = 1'b0; rst3 = 1'b0;

        // 1: reset state
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_rden", longint'(rden), 0);
        chk("rst_valid", longint'(dv), 0);
        chk("rst_addr", longint'(addr), 0);
        chk("rst_data_zero", longint'(dout == '0), 1);
`ifdef CHANNEL_READER_STALL_CNT_EN
        chk("rst_stall", longint'(stall), 0);
`endif
        step();

        // 2: free-running frame
        push_seq(seq_plain);
        d0 = done_cnt;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!rden && n < 10) begin step(); n++; end
        run = 1;
        repeat (11) begin step(); if (rden) run++; end
        chk("consecutive_reads", run, 12);
        wait_done("t2");
        chk("t2_done_pulses", done_cnt - d0, 1);
        leftovers("t2");

        // 3: channel 1 held for 20 cycles from start
        push_seq(seq_hold1);
        d0 = done_cnt;
        hold = 3'b010; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            start = 1'b0;
            if (i == 12 || i == 19) begin
                chk("held_ch1_valid", longint'(dv[1]), 1);
                chk("held_ch1_data", longint'(dout[DW +: DW]), 4);
            end
        end
        hold = '0;
        wait_done("t3");
        chk("t3_done_pulses", done_cnt - d0, 1);
        leftovers("t3");

        // 4a: start pulsed during RUN is ignored
        push_seq(seq_plain);
        d0 = done_cnt;
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        wait_done("t4a");
        chk("t4a_done_pulses", done_cnt - d0, 1);
        leftovers("t4a");

        // 4b: reset after 5 issued reads
        exp_a.push_back(0); exp_a.push_back(4); exp_a.push_back(8);
        exp_a.push_back(1); exp_a.push_back(5);
        exp_d[0].push_back(0); exp_d[1].push_back(4); exp_d[2].push_back(8);
        start = 1'b1; step(); start = 1'b0;
        cnt = 0; n = 0;
        while (cnt < 5 && n < 50) begin
            step();
            n++;
            if (rden) cnt++;
        end
        chk("t4b_five_reads", cnt, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4b_busy", longint'(busy), 0);
        chk("t4b_rden", longint'(rden), 0);
        chk("t4b_addr", longint'(addr), 0);
        chk("t4b_valid", longint'(dv), 0);
        chk("t4b_data_zero", longint'(dout == '0), 1);
        bad = 0;
        repeat (6) begin step(); if (dv != '0 || rden) bad++; end
        chk("t4b_quiet_after_reset", bad, 0);
        leftovers("t4b");
        push_seq(seq_plain);
        d0 = done_cnt;
        start = 1'b1; step(); start = 1'b0;
        wait_done("t4c");
        chk("t4c_done_pulses", done_cnt - d0, 1);
        leftovers("t4c");

        // 5: latency 3, random hold
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < 4; k++) exp3[c].push_back(4*c + k);
        start3 = 1'b1; step(); start3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 400) begin
            hold3 = 3'($urandom_range(0, 7));
            step();
            n++;
        end
        chk("t5_done_seen", longint'(n < 400), 1);
        hold3 = '0;
        repeat (2) step();
        chk("t5_done_pulses", done3_cnt, 1);
        chk("t5_data_left", exp3[0].size() + exp3[1].size() + exp3[2].size(), 0);

`ifdef CHANNEL_READER_STALL_CNT_EN
        // 6: all channels held for 10 cycles starting with the start cycle
        push_seq(seq_plain);
        hold = 3'b111; start = 1'b1;
        repeat (10) begin step(); start = 1'b0; end
        hold = '0;
        wait_done("t6");
        chk("t6_stall_cnt", longint'(stall), 4);
        repeat (3) step();
        chk("t6_stall_hold_idle", longint'(stall), 4);
        leftovers("t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
